// File: rtl/audio_recorder.sv
// Left-channel I2S capture stage: deserializes 16-bit ADC samples on BCLK and
// writes them to sequential SRAM addresses with start/pause/resume/stop control.
module audio_recorder #(
  parameter int unsigned             ADDR_W   = 20,
  parameter int unsigned             SAMPLE_W = 16,
  parameter logic [ADDR_W-1:0]       MAX_ADDR = 20'hFFFFF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_init_done,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_lrc,
  input  logic                i_data,
  output logic [ADDR_W-1:0]   o_address,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_wr,
  output logic                o_busy,
  output logic [ADDR_W-1:0]   o_length
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_L,
    SHIFT,
    WRITE,
    PAUSED
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                lrc_q, lrc_d;
  logic                pend_q, pend_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      lrc_q   <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      lrc_q   <= lrc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    lrc_d   = i_lrc;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (i_start && i_init_done && !i_stop) begin
          state_d = WAIT_L;
          addr_d  = '0;
          len_d   = '0;
        end
      end
      WAIT_L: begin
        if (i_stop) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end else if (i_pause || pend_q) begin
          state_d = PAUSED;
          pend_d  = 1'b0;
        end else if (lrc_q && !i_lrc) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (i_stop) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end else begin
          // Pause only latches here; the word in flight still gets written.
          if (i_pause) pend_d = 1'b1;
          shreg_d = {shreg_q[SAMPLE_W-2:0], i_data};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = WRITE;
            data_d  = {shreg_q[SAMPLE_W-2:0], i_data};
            wr_d    = 1'b1;
          end
        end
      end
      WRITE: begin
        len_d = addr_q + 1'b1;
        if (addr_q == MAX_ADDR) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
          if (i_stop) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end else if (pend_q || i_pause) begin
            state_d = PAUSED;
            pend_d  = 1'b0;
          end else begin
            state_d = WAIT_L;
          end
        end
      end
      PAUSED: begin
        pend_d = 1'b0;
        if (i_stop) state_d = IDLE;
        else if (!i_pause && i_start) state_d = WAIT_L;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign o_address = addr_q;
  assign o_length  = len_q;
  assign o_data    = data_q;
  assign o_wr      = wr_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Scoreboard bench for audio_recorder: I2S frames are generated per task, expected
// writes are queued as frames are driven and checked whenever the strobe fires.
module tb_audio_recorder;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned SAMPLE_W = 16;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_init_done = 1'b0;
  logic                i_start = 1'b0;
  logic                i_pause = 1'b0;
  logic                i_stop = 1'b0;
  logic                i_lrc = 1'b1;
  logic                i_data = 1'b0;
  logic [ADDR_W-1:0]   o_address;
  logic [SAMPLE_W-1:0] o_data;
  logic                o_wr;
  logic                o_busy;
  logic [ADDR_W-1:0]   o_length;

  typedef struct {
    logic [ADDR_W-1:0]   a;
    logic [SAMPLE_W-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  audio_recorder #(
    .ADDR_W  (ADDR_W),
    .SAMPLE_W(SAMPLE_W),
    .MAX_ADDR(20'd3)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_init_done(i_init_done),
    .i_start    (i_start),
    .i_pause    (i_pause),
    .i_stop     (i_stop),
    .i_lrc      (i_lrc),
    .i_data     (i_data),
    .o_address  (o_address),
    .o_data     (o_data),
    .o_wr       (o_wr),
    .o_busy     (o_busy),
    .o_length   (o_length)
  );

  always #5 i_clk = ~i_clk;

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (o_wr === 1'b1) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", o_address, o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_address !== e.a || o_data !== e.d) begin
          nerr++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   o_address, o_data, e.a, e.d);
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_lrc  = 1'b1;
      i_data = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge i_clk);
    i_lrc   = 1'b1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge i_clk);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
  endtask

  // One I2S frame of 18+18 BCLKs. Left bits sit on cycles 1..16 after the LRC fall.
  // exp_addr < 0 means no write is expected. ev_kind: 0 none, 1 pause, 2 stop, 3 reset.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int exp_addr, input int ev_cyc, input int ev_kind);
    exp_t e;
    if (exp_addr >= 0) begin
      e.a = ADDR_W'(exp_addr);
      e.d = l;
      sb.push_back(e);
    end
    for (int j = 0; j < 36; j++) begin
      @(negedge i_clk);
      i_pause = 1'b0;
      i_stop  = 1'b0;
      i_rst   = 1'b0;
      i_lrc   = (j >= 18);
      if (j >= 1 && j <= 16)       i_data = l[16-j];
      else if (j >= 19 && j <= 34) i_data = r[34-j];
      else                         i_data = 1'b0;
      if (j == ev_cyc) begin
        if (ev_kind == 1) i_pause = 1'b1;
        if (ev_kind == 2) i_stop  = 1'b1;
        if (ev_kind == 3) begin
          #2 i_rst = 1'b1;
          #1;
          nvec++;
          if (o_address !== '0 || o_data !== '0 || o_wr !== 1'b0 ||
              o_busy !== 1'b0 || o_length !== '0) begin
            nerr++;
            $display("FAIL async_reset: got addr=%0d data=%h wr=%b busy=%b len=%0d, required all 0",
                     o_address, o_data, o_wr, o_busy, o_length);
          end
        end
      end
    end
    @(negedge i_clk);
    i_pause = 1'b0;
    i_stop  = 1'b0;
    i_rst   = 1'b0;
    i_lrc   = 1'b1;
    i_data  = 1'b0;
  endtask

  task automatic check_state(input string name, input logic busy,
                             input int addr, input int len);
    nvec++;
    if (o_busy !== busy || o_address !== ADDR_W'(addr) || o_length !== ADDR_W'(len)) begin
      nerr++;
      $display("FAIL %s: got busy=%b addr=%0d len=%0d, required busy=%b addr=%0d len=%0d",
               name, o_busy, o_address, o_length, busy, addr, len);
    end
  endtask

  task automatic check_drained(input string name);
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL %s_missing_writes: got %0d pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    nvec++;
    if (o_address !== '0 || o_data !== '0 || o_wr !== 1'b0 || o_busy !== 1'b0 || o_length !== '0) begin
      nerr++;
      $display("FAIL reset: got addr=%0d data=%h wr=%b busy=%b len=%0d, required all 0",
               o_address, o_data, o_wr, o_busy, o_length);
    end
    i_rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_init_gating();
    pulse_start();
    idle_cycles(1);
    check_state("init_gated", 1'b0, 0, 0);
    i_init_done = 1'b1;
    pulse_start();
    check_state("init_start", 1'b1, 0, 0);
  endtask

  task automatic test_single_sample();
    send_frame(16'hA5C3, 16'hFFFF, 0, -1, 0);
    check_state("single_after", 1'b1, 1, 1);
    check_drained("single");
  endtask

  task automatic test_right_ignored();
    pulse_stop();
    check_state("stop_idle", 1'b0, 1, 1);
    pulse_start();
    check_state("restart_clear", 1'b1, 0, 0);
    for (int k = 0; k < 3; k++) send_frame(16'(k + 1), 16'hFFFF, k, -1, 0);
    check_state("right_after", 1'b1, 3, 3);
    check_drained("right");
  endtask

  task automatic test_pause();
    pulse_stop();
    pulse_start();
    send_frame(16'h1234, 16'hFFFF, 0, -1, 0);
    send_frame(16'h5678, 16'hFFFF, 1, 8, 1);
    check_state("pause_entered", 1'b1, 2, 2);
    for (int k = 0; k < 5; k++) send_frame(16'hDEAD, 16'hBEEF, -1, -1, 0);
    check_state("pause_held", 1'b1, 2, 2);
    pulse_start();
    send_frame(16'h9ABC, 16'h0000, 2, -1, 0);
    check_state("resume_after", 1'b1, 3, 3);
    check_drained("pause");
  endtask

  task automatic test_stop_and_wrap();
    pulse_stop();
    pulse_start();
    send_frame(16'h1111, 16'hFFFF, 0, -1, 0);
    send_frame(16'h2222, 16'hFFFF, -1, 5, 2);
    check_state("stop_partial", 1'b0, 1, 1);
    pulse_start();
    send_frame(16'hC000, 16'hFFFF, 0, -1, 0);
    send_frame(16'hC001, 16'hFFFF, 1, -1, 0);
    send_frame(16'hC002, 16'hFFFF, 2, -1, 0);
    send_frame(16'hC003, 16'hFFFF, 3, -1, 0);
    send_frame(16'hC004, 16'hFFFF, -1, -1, 0);
    send_frame(16'hC005, 16'hFFFF, -1, -1, 0);
    check_state("wrap_autostop", 1'b0, 3, 4);
    check_drained("wrap");
  endtask

  task automatic test_reset_mid_shift();
    pulse_start();
    send_frame(16'h7777, 16'hFFFF, -1, 10, 3);
    check_state("post_reset", 1'b0, 0, 0);
    pulse_start();
    send_frame(16'h4242, 16'hFFFF, 0, -1, 0);
    check_state("post_reset_rec", 1'b1, 1, 1);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_single_sample();
    test_right_ignored();
    test_pause();
    test_stop_and_wrap();
    test_reset_mid_shift();
    idle_cycles(4);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/audio_recorder.md
Name: audio_recorder

Overview:
- Capture stage directly downstream of the codec I2C initializer.
- After the codec is configured, deserializes left-channel ADC samples from the codec's I2S bit stream.
- Writes each sample as one 16-bit word to sequential SRAM addresses through a single-cycle write strobe.
- Supports start, pause, resume and stop control from the top-level FSM, and reports the recorded length.

Parameters:
ADDR_W, 20, width of SRAM word address
SAMPLE_W, 16, bits per captured sample (codec configured for 16-bit I2S)
MAX_ADDR, 20'hFFFFF, last writable address; recording auto-stops after writing it

Ports:
i_clk  input  1  codec bit clock (BCLK); all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_init_done  input  1  codec configuration finished; i_start ignored while low
i_start  input  1  level-sampled; starts new recording from IDLE, resumes from PAUSED
i_pause  input  1  request pause
i_stop  input  1  request stop
i_lrc  input  1  codec ADCLRCK; low = left channel
i_data  input  1  codec ADCDAT serial data
o_address  output  ADDR_W  SRAM write address
o_data  output  SAMPLE_W  sample to write
o_wr  output  1  one-cycle write strobe
o_busy  output  1  high in any state except IDLE
o_length  output  ADDR_W  samples written in last/current recording

Behaviour:
- Reset: state IDLE; o_address=0, o_data=0, o_wr=0, o_busy=0, o_length=0; lrc history register=1; bit counter=0.
- All outputs are registered.
- States:
  - IDLE: on i_start & i_init_done & !i_stop -> WAIT_L; clear o_address and o_length to 0.
  - WAIT_L: wait for falling LRC, i.e. registered lrc_d=1 and i_lrc=0 at edge k -> SHIFT with bit counter=0.
  - SHIFT: I2S one-BCLK delay; edges k+1..k+16 shift i_data into the sample register MSB-first. At edge k+16 -> WRITE, with o_data=captured word and o_wr=1 valid for the cycle after that edge.
  - WRITE: one cycle only. Next edge: o_wr=0, o_length=o_address+1.
    - If o_address==MAX_ADDR -> IDLE (auto-stop; address not incremented).
    - Else o_address+1 and -> PAUSED if a pause is pending, otherwise -> WAIT_L.
  - PAUSED: no capture, o_wr=0. i_start -> WAIT_L with address kept; i_stop -> IDLE.
- Right-channel half-frame (i_lrc=1) is never captured.
- A rising LRC mid-SHIFT is ignored; the bit counter alone ends the word.
- Pause in WAIT_L or SHIFT:
  - Sets a pending flag.
  - In WAIT_L, the block goes to PAUSED on the next edge.
  - In SHIFT, the current sample completes and is written first.
- Stop in WAIT_L, SHIFT or PAUSED: next edge -> IDLE.
  - A partial sample is discarded (no o_wr).
  - o_length keeps the count of completed writes.
- Stop in WRITE: the current write completes, then -> IDLE.
- Simultaneous requests: priority is stop > pause > start. i_start in states other than IDLE/PAUSED is ignored.
- o_busy = (state != IDLE).
- o_address and o_length stay stable after returning to IDLE until the next start.
- Async reset mid-frame or mid-write: immediate return to reset values; o_wr deasserts asynchronously.

Test Plan:
- Init gating: i_init_done=0, pulse i_start -> stays IDLE, o_busy=0. Set i_init_done=1, pulse i_start -> WAIT_L, o_busy=1.
- Single sample: drive LRC low with i_data pattern 16'hA5C3 MSB-first starting 1 BCLK after the LRC fall -> one o_wr pulse with o_data=16'hA5C3, o_address=0; next cycle o_address=1, o_length=1.
- Right channel ignored: 3 full LRC frames, right data 16'hFFFF, left data 16'h0001/0002/0003 -> exactly 3 writes, data 1,2,3 at addresses 0,1,2.
- Pause mid-sample: assert i_pause at bit 8 of the second sample -> sample written at address 1, then PAUSED with no writes for 5 frames. i_start -> next left sample written at address 2.
- Stop and wrap: stop at bit 5 -> no write, IDLE, o_length unchanged. With MAX_ADDR=3, record 6 frames -> writes at 0..3 only, auto IDLE, o_length=4.
- Reset mid-SHIFT: assert i_rst at bit 10 -> all outputs 0 immediately. After release, a new start records from address 0.
